// File: rtl/seq_word_comparator.sv
// Bit-serial magnitude comparator: accepts WIDTH a/b bit pairs and reports eq/gt/lt.
// Bit order and signedness decide which differing pair owns the final decision.
module seq_word_comparator #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic signed_mode,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    // The sign bit is the first pair when MSB-first, the last pair otherwise.
    localparam logic [CW-1:0] SIGN_CNT = (MSB_FIRST != 0) ? {CW{1'b0}} : LAST_CNT;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {DEC_NONE, DEC_GT, DEC_LT} dec_t;

    state_t        state;
    dec_t          dec;
    dec_t          dec_next;
    dec_t          pair_dec;
    logic [CW-1:0] cnt;
    logic          signed_q;
    logic          sign_pair;
    logic          last_pair;

    always_comb begin
        sign_pair = signed_q && (cnt == SIGN_CNT);
        last_pair = (cnt == LAST_CNT);
        pair_dec  = (a ^ sign_pair) ? DEC_GT : DEC_LT;
        dec_next  = dec;
        if ((a ^ b) && ((MSB_FIRST == 0) || (dec == DEC_NONE))) begin
            dec_next = pair_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dec      <= DEC_NONE;
            signed_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Restart from any state; the pair on the start cycle is dropped.
                state    <= SHIFT;
                busy     <= 1'b1;
                cnt      <= '0;
                dec      <= DEC_NONE;
                signed_q <= signed_mode;
            end else begin
                case (state)
                    SHIFT: begin
                        if (in_valid) begin
                            cnt <= cnt + CW'(1);
                            dec <= dec_next;
                            if (last_pair) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                eq    <= (dec_next == DEC_NONE);
                                gt    <= (dec_next == DEC_GT);
                                lt    <= (dec_next == DEC_LT);
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_word_comparator.sv
// Bench for seq_word_comparator: MSB-first and LSB-first 4-bit instances fed the same words,
// plus a 1-bit instance; a word-level integer model is checked every cycle.
module tb_seq_word_comparator;
    logic clk = 1'b0;
    logic rst;
    logic st[3], sm[3], vl[3], ai[3], bi[3];
    logic busy_s[3], done_s[3], eq_s[3], gt_s[3], lt_s[3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int gap_total = 0;
    int done_cnt = 0;
    int d0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (done_s[0]) done_cnt++;

    seq_word_comparator #(.WIDTH(4), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(rst), .start(st[0]), .signed_mode(sm[0]), .in_valid(vl[0]),
        .a(ai[0]), .b(bi[0]), .busy(busy_s[0]), .done(done_s[0]), .eq(eq_s[0]), .gt(gt_s[0]), .lt(lt_s[0]));
    seq_word_comparator #(.WIDTH(4), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(rst), .start(st[1]), .signed_mode(sm[1]), .in_valid(vl[1]),
        .a(ai[1]), .b(bi[1]), .busy(busy_s[1]), .done(done_s[1]), .eq(eq_s[1]), .gt(gt_s[1]), .lt(lt_s[1]));
    seq_word_comparator #(.WIDTH(1), .MSB_FIRST(1)) dut2 (
        .clk(clk), .reset(rst), .start(st[2]), .signed_mode(sm[2]), .in_valid(vl[2]),
        .a(ai[2]), .b(bi[2]), .busy(busy_s[2]), .done(done_s[2]), .eq(eq_s[2]), .gt(gt_s[2]), .lt(lt_s[2]));

    // Word-level model: collect bits into integers, compare numerically when the word completes.
    bit   m_act[3], m_sg[3];
    int   m_cnt[3], m_wa[3], m_wb[3];
    logic e_busy[3], e_done[3], e_eq[3], e_gt[3], e_lt[3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int w, pos;
            longint va, vb;
            w = (d == 2) ? 1 : 4;
            e_done[d] = 1'b0;
            if (rst) begin
                m_act[d] = 1'b0;
                e_eq[d] = 1'b0; e_gt[d] = 1'b0; e_lt[d] = 1'b0;
            end else if (st[d]) begin
                m_act[d] = 1'b1; m_cnt[d] = 0; m_wa[d] = 0; m_wb[d] = 0; m_sg[d] = sm[d];
            end else if (m_act[d] && vl[d]) begin
                pos = (d == 1) ? m_cnt[d] : w - 1 - m_cnt[d];
                m_wa[d] |= int'(ai[d]) << pos;
                m_wb[d] |= int'(bi[d]) << pos;
                m_cnt[d]++;
                if (m_cnt[d] == w) begin
                    m_act[d] = 1'b0;
                    e_done[d] = 1'b1;
                    va = m_wa[d];
                    vb = m_wb[d];
                    if (m_sg[d] && va >= (longint'(1) << (w - 1))) va -= longint'(1) << w;
                    if (m_sg[d] && vb >= (longint'(1) << (w - 1))) vb -= longint'(1) << w;
                    e_eq[d] = (va == vb); e_gt[d] = (va > vb); e_lt[d] = (va < vb);
                end
            end
            e_busy[d] = m_act[d];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if ({busy_s[d], done_s[d], eq_s[d], gt_s[d], lt_s[d]} !==
                    {e_busy[d], e_done[d], e_eq[d], e_gt[d], e_lt[d]}) begin
                    miscompares++;
                    $display("FAIL model dut%0d cycle %0d: busy/done/eq/gt/lt got %b required %b", d, cyc,
                             {busy_s[d], done_s[d], eq_s[d], gt_s[d], lt_s[d]},
                             {e_busy[d], e_done[d], e_eq[d], e_gt[d], e_lt[d]});
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; vl[d] = 1'b0;
            ai[d] = 1'($urandom_range(0, 1)); bi[d] = 1'($urandom_range(0, 1));
            sm[d] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    // Start with a valid garbage pair (must be discarded); signed_mode is scrambled afterwards.
    task automatic pulse_start(input logic sg);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b1; sm[d] = sg; vl[d] = 1'b1;
            ai[d] = 1'($urandom_range(0, 1)); bi[d] = 1'($urandom_range(0, 1));
        end
        start_cyc = cyc;
        gap_total = 0;
    endtask

    task automatic send_bits(input logic [3:0] wa, input logic [3:0] wb, input int first, input int last,
                             input int gap_max, input bit start_on_last);
        for (int k = first; k <= last; k++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(gap_max, 1) : 0;
            gap_total += g;
            idle(g);
            @(negedge clk);
            clear_inputs();
            for (int d = 0; d < 2; d++) begin
                vl[d] = 1'b1;
                st[d] = start_on_last && (k == last);
            end
            if (start_on_last && (k == last)) begin
                sm[0] = 1'b0; sm[1] = 1'b0;
                start_cyc = cyc;
            end
            ai[0] = wa[3 - k]; bi[0] = wb[3 - k];
            ai[1] = wa[k];     bi[1] = wb[k];
        end
    endtask

    task automatic wait_done(input string name, input logic [2:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        clear_inputs();
        while (!done_s[0] && n < 20) begin
            @(negedge clk);
            clear_inputs();
            n++;
        end
        check_lit({name, " done dut0"}, 32'(done_s[0]), 32'd1);
        check_lit({name, " done dut1"}, 32'(done_s[1]), 32'd1);
        check_lit({name, " result dut0"}, 32'({eq_s[0], gt_s[0], lt_s[0]}), 32'(exp_res));
        check_lit({name, " result dut1"}, 32'({eq_s[1], gt_s[1], lt_s[1]}), 32'(exp_res));
        if (exp_lat > 0) check_lit({name, " latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
    endtask

    task automatic run_w1(input string name, input logic sg, input logic av, input logic bv,
                          input logic [2:0] exp_res);
        @(negedge clk);
        st[2] = 1'b1; sm[2] = sg; vl[2] = 1'b0;
        @(negedge clk);
        st[2] = 1'b0; sm[2] = ~sg; vl[2] = 1'b1; ai[2] = av; bi[2] = bv;
        @(negedge clk);
        vl[2] = 1'b0;
        check_lit({name, " done"}, 32'(done_s[2]), 32'd1);
        check_lit({name, " result"}, 32'({eq_s[2], gt_s[2], lt_s[2]}), 32'(exp_res));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; sm[d] = 1'b0; vl[d] = 1'b0; ai[d] = 1'b0; bi[d] = 1'b0;
            m_act[d] = 1'b0; m_sg[d] = 1'b0; m_cnt[d] = 0; m_wa[d] = 0; m_wb[d] = 0;
            e_busy[d] = 1'b0; e_done[d] = 1'b0; e_eq[d] = 1'b0; e_gt[d] = 1'b0; e_lt[d] = 1'b0;
        end
        // Reset must win over a simultaneous start and valid pair.
        rst = 1'b1;
        st[0] = 1'b1; st[1] = 1'b1; vl[0] = 1'b1; vl[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset outputs dut0", 32'({busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]}), 32'd0);
        check_lit("reset outputs dut1", 32'({busy_s[1], done_s[1], eq_s[1], gt_s[1], lt_s[1]}), 32'd0);
        rst = 1'b0;
        clear_inputs();
        idle(2);

        pulse_start(1'b0); send_bits(4'b0110, 4'b1100, 0, 3, 0, 0); wait_done("u 0110/1100", 3'b001, 5);
        pulse_start(1'b1); send_bits(4'b0110, 4'b1100, 0, 3, 0, 0); wait_done("s 0110/1100", 3'b010, 5);
        pulse_start(1'b1); send_bits(4'b1000, 4'b0111, 0, 3, 0, 0); wait_done("s 1000/0111", 3'b001, 5);
        pulse_start(1'b0); send_bits(4'b1000, 4'b0111, 0, 3, 0, 0); wait_done("u 1000/0111", 3'b010, 5);
        pulse_start(1'b0); send_bits(4'b1010, 4'b1010, 0, 3, 0, 0); wait_done("eq 1010", 3'b100, 5);

        pulse_start(1'b0); send_bits(4'b0110, 4'b1100, 0, 3, 3, 0);
        wait_done("gaps 0110/1100", 3'b001, 5 + gap_total);

        // Restart after two bits: only the second word may produce a done.
        idle(1);
        d0 = done_cnt;
        pulse_start(1'b0); send_bits(4'b1111, 4'b0000, 0, 1, 0, 0);
        pulse_start(1'b0); send_bits(4'b0101, 4'b0101, 0, 3, 0, 0); wait_done("restart eq", 3'b100, 5);
        idle(1);
        check_lit("restart single done", 32'(done_cnt - d0), 32'd1);

        // Reset after three bits, with start held in the reset cycle.
        d0 = done_cnt;
        pulse_start(1'b0); send_bits(4'b0110, 4'b1100, 0, 2, 0, 0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1; st[0] = 1'b1; st[1] = 1'b1; vl[0] = 1'b1; vl[1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        check_lit("mid reset busy/eq/gt/lt", 32'({busy_s[0], eq_s[0], gt_s[0], lt_s[0]}), 32'd0);
        idle(6);
        check_lit("mid reset no done", 32'(done_cnt - d0), 32'd0);

        // Start on the 4th bit aborts without done; the previous gt result must hold.
        pulse_start(1'b0); send_bits(4'b1100, 4'b0110, 0, 3, 0, 0); wait_done("u 1100/0110", 3'b010, 5);
        idle(1);
        d0 = done_cnt;
        pulse_start(1'b1); send_bits(4'b0000, 4'b1111, 0, 3, 0, 1);
        @(negedge clk);
        clear_inputs();
        check_lit("abort no done", 32'(done_s[0]), 32'd0);
        check_lit("abort busy", 32'(busy_s[0]), 32'd1);
        check_lit("abort result held", 32'({eq_s[0], gt_s[0], lt_s[0]}), 32'b010);
        send_bits(4'b0011, 4'b0011, 0, 3, 0, 0); wait_done("after abort eq", 3'b100, 0);
        idle(1);
        check_lit("abort single done", 32'(done_cnt - d0), 32'd1);

        for (int i = 0; i < 6; i++) begin
            pulse_start(1'($urandom_range(0, 1)));
            send_bits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 3, $urandom_range(0, 2), 0);
            idle(3);
        end

        run_w1("w1 s 1/0", 1'b1, 1'b1, 1'b0, 3'b001);
        run_w1("w1 u 1/0", 1'b0, 1'b1, 1'b0, 3'b010);
        run_w1("w1 s 0/1", 1'b1, 1'b0, 1'b1, 3'b010);
        run_w1("w1 s 1/1", 1'b1, 1'b1, 1'b1, 3'b100);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_word_comparator.md
SEQ_WORD_COMPARATOR -- requirements
Module: seq_word_comparator

Interface
REQ-001 Parameter WIDTH, 8, bits per compared word; legal range 1..64.
REQ-002 Parameter MSB_FIRST, 1, bit order: 1 = MSB arrives first, 0 = LSB arrives first.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  begins a new word comparison; aborts any word in progress.
REQ-006 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on the start cycle only.
REQ-007 Port in_valid  input  1  the current a/b bit pair is valid.
REQ-008 Port a  input  1  serial bit of operand A.
REQ-009 Port b  input  1  serial bit of operand B.
REQ-010 Port busy  output  1  a word is being accepted.
REQ-011 Port done  output  1  one-cycle pulse; the result registers were updated this cycle.
REQ-012 Port eq  output  1  A == B for the last completed word.
REQ-013 Port gt  output  1  A > B for the last completed word.
REQ-014 Port lt  output  1  A < B for the last completed word.

Function
REQ-015 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 In any state, start=1 SHALL move the FSM to SHIFT, clear the bit counter and internal decision, latch signed_mode, and discard any a/b bit presented in that cycle.
REQ-017 In SHIFT, a bit pair SHALL be accepted only on cycles with in_valid=1; in_valid=0 stalls with all state held.
REQ-018 The bit counter SHALL be $clog2(WIDTH+1) bits wide and increment once per accepted pair.
REQ-019 With MSB_FIRST=1, the first differing pair SHALL set the internal decision, and later pairs SHALL NOT change it.
REQ-020 With MSB_FIRST=0, every differing pair SHALL overwrite the internal decision, so the last differing pair wins.
REQ-021 For a differing pair, the decision SHALL be gt if a=1, otherwise lt.
REQ-022 When signed_mode=1 and the differing pair is the sign bit (bit WIDTH-1), the decision SHALL be inverted, with a=1 giving lt.
REQ-023 On accepting the WIDTH-th pair, the FSM SHALL enter DONE, and the next cycle SHALL show done=1, busy=0 and eq/gt/lt holding the final decision.
REQ-024 A word with no differing pair SHALL give eq=1 and gt=lt=0.
REQ-025 Exactly one of eq/gt/lt SHALL be 1 after the first done, and all three SHALL be 0 before it.
REQ-026 DONE SHALL last one cycle and then return to IDLE, unless start=1 in that cycle, which gives SHIFT.
REQ-027 eq/gt/lt SHALL change only in a done cycle or on reset, and hold through later IDLE and SHIFT cycles.
REQ-028 busy SHALL be 1 exactly while in SHIFT.
REQ-029 start=1 in the same cycle as the WIDTH-th valid pair SHALL abort the word with no done pulse, and the results SHALL be unchanged.
REQ-030 With WIDTH=1, the single bit is the sign bit, and signed_mode SHALL treat 1 as -1.
REQ-031 Latency from start to done SHALL be WIDTH+1 cycles when in_valid is held high from the cycle after start.

Reset
REQ-032 With reset=1 at a rising edge: state = IDLE, counter = 0, decision cleared, busy = done = eq = gt = lt = 0.
REQ-033 Reset SHALL override start and in_valid in the same cycle.
REQ-034 Reset mid-word SHALL discard the partial word, and no done SHALL follow.

Verification
REQ-035 WIDTH=4, MSB_FIRST=1, unsigned, A=0110, B=1100, in_valid held high -> done 5 cycles after start, lt=1, eq=gt=0.
REQ-036 Same words with signed_mode=1 (6 vs -4) -> gt=1; WIDTH=4 with A=1000, B=0111, signed -> lt=1, unsigned -> gt=1.
REQ-037 MSB_FIRST=0, A=0110, B=1100 sent LSB first (A bits 0,1,1,0; B bits 0,0,1,1) -> lt=1; A=B=1010 -> eq=1.
REQ-038 in_valid gaps of 1-3 cycles between bits -> same result as the gap-free run; done delayed by the total gap length; busy=1 throughout.
REQ-039 start re-asserted after 2 bits, then a full new word of equal operands -> exactly one done, eq=1, and the first word is ignored.
REQ-040 Reset asserted after 3 bits -> busy=0 next cycle, no done, eq=gt=lt=0; start coinciding with the 4th bit -> no done, prior result held.
